// File: rtl/led_pattern_driver.sv
// led_pattern_driver: turns the blink heartbeat into a dimmed LED drive.
// Four modes (off, solid, rotating pattern, breathing) share one free-running
// PWM counter. Each synchronised tick_in rising edge is a "step" that rotates
// the pattern register and moves the breathe level one increment.
module led_pattern_driver #(
  parameter int PWM_BITS     = 8,
  parameter int PATTERN_BITS = 8,
  parameter int BREATHE_STEP = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tick_in,
  input  logic [1:0]              mode,
  input  logic [PWM_BITS-1:0]     duty,
  input  logic [PATTERN_BITS-1:0] pattern,
  input  logic                    pattern_load,
  output logic                    step_out,
  output logic                    led_out
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_SOLID   = 2'b01,
    MODE_PATTERN = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;
  localparam logic [PWM_BITS:0]   LEVEL_MAX = {1'b0, PWM_MAX};
  // Breathe arithmetic is one bit wider than the level so over/underflow is visible.
  localparam logic [PWM_BITS:0]   STEP_INC  = (PWM_BITS + 1)'(BREATHE_STEP);

  // Synchroniser, edge history and the registered step pulse.
  logic sync1_q, sync2_q, hist_q, step_q;

  logic [PWM_BITS-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0]     duty_q, duty_d;
  logic [PATTERN_BITS-1:0] pat_q, pat_d;
  logic [PWM_BITS-1:0]     level_q, level_d;
  dir_e                    dir_q, dir_d;
  mode_e                   mode_q, mode_d;
  logic                    led_q, led_d;

  logic [PWM_BITS:0] level_sum;
  logic [PWM_BITS:0] level_diff;
  logic              pwm_on;
  logic              enter_breathe;

  assign level_sum     = {1'b0, level_q} + STEP_INC;
  assign level_diff    = {1'b0, level_q} - STEP_INC;
  assign pwm_on        = (pwm_cnt_q < duty_q);
  assign enter_breathe = (mode_e'(mode) == MODE_BREATHE) && (mode_q != MODE_BREATHE);

  // Two-flop synchroniser on tick_in, then a rising-edge detector registered into step_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value,
      // so the chain shifts one stage per clock instead of collapsing.
      sync1_q <= tick_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      step_q  <= sync2_q & ~hist_q;
    end
  end

  // PWM counter, period-aligned duty capture, pattern load/rotate and mode copy.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which is what would otherwise infer a latch.
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    duty_d    = duty_q;
    pat_d     = pat_q;
    mode_d    = mode_e'(mode);

    // Duty only changes at the end of a period so a PWM pulse is never cut short.
    if (pwm_cnt_q == PWM_MAX) begin
      duty_d = duty;
    end

    // A load on the same cycle as a step wins and suppresses that rotation.
    if (pattern_load) begin
      pat_d = pattern;
    end else if (step_q) begin
      pat_d = {pat_q[PATTERN_BITS-2:0], pat_q[PATTERN_BITS-1]};
    end
  end

  // Breathe direction FSM: ramps level up to full, then down to zero, one increment per step.
  always_comb begin
    level_d = level_q;
    dir_d   = dir_q;

    if (enter_breathe) begin
      level_d = '0;
      dir_d   = DIR_UP;
    end else if ((mode_q == MODE_BREATHE) && step_q) begin
      case (dir_q)
        DIR_UP: begin
          if (level_sum >= LEVEL_MAX) begin
            level_d = PWM_MAX;
            dir_d   = DIR_DOWN;
          end else begin
            level_d = level_sum[PWM_BITS-1:0];
          end
        end
        DIR_DOWN: begin
          // A borrow out of the top bit means the subtraction went below zero.
          if (level_diff[PWM_BITS] || (level_diff == '0)) begin
            level_d = '0;
            dir_d   = DIR_UP;
          end else begin
            level_d = level_diff[PWM_BITS-1:0];
          end
        end
        default: begin
          level_d = '0;
          dir_d   = DIR_UP;
        end
      endcase
    end
  end

  // LED drive selected by the registered mode.
  always_comb begin
    led_d = 1'b0;
    case (mode_q)
      MODE_OFF:     led_d = 1'b0;
      MODE_SOLID:   led_d = pwm_on;
      MODE_PATTERN: led_d = pat_q[PATTERN_BITS-1] & pwm_on;
      MODE_BREATHE: led_d = (pwm_cnt_q < level_q);
      default:      led_d = 1'b0;
    endcase
  end

  // State registers for PWM, pattern, breathe FSM, mode and the LED output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      pat_q     <= '0;
      level_q   <= '0;
      dir_q     <= DIR_UP;
      mode_q    <= MODE_OFF;
      led_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      pat_q     <= pat_d;
      level_q   <= level_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      led_q     <= led_d;
    end
  end

  assign step_out = step_q;
  assign led_out  = led_q;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Testbench for led_pattern_driver: PWM duty table, hand-written multi-cycle
// sequences (step latency, pattern rotation, load/step collision, breathe ramp,
// reset mid-ramp) and a randomized run against a behavioural reference model.
module tb_led_pattern_driver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick_in;
  logic [1:0] mode;
  logic [7:0] duty;
  logic [7:0] pattern;
  logic       pattern_load;
  logic       step_out;
  logic       led_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_pattern_driver #(
    .PWM_BITS    (8),
    .PATTERN_BITS(8),
    .BREATHE_STEP(16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick_in     (tick_in),
    .mode        (mode),
    .duty        (duty),
    .pattern     (pattern),
    .pattern_load(pattern_load),
    .step_out    (step_out),
    .led_out     (led_out)
  );

  // Reference model state, kept as plain integers.
  int m_cnt, m_duty, m_pat, m_level, m_mode;
  bit m_rising, m_step, m_led;
  bit s1, s2, s3;  // tick_in samples at the last three clock edges, newest first

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_duty = 0; m_pat = 0; m_level = 0; m_mode = 0;
    m_rising = 1'b1; m_step = 1'b0; m_led = 1'b0;
    s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int  cnt_old   = m_cnt;
    int  duty_old  = m_duty;
    int  pat_old   = m_pat;
    int  lvl_old   = m_level;
    int  mode_old  = m_mode;
    bit  step_old  = m_step;
    case (mode_old)
      0:       m_led = 1'b0;
      1:       m_led = (cnt_old < duty_old);
      2:       m_led = (pat_old >= 128) && (cnt_old < duty_old);
      default: m_led = (cnt_old < lvl_old);
    endcase
    if (cnt_old == 255) m_duty = int'(duty);
    m_cnt = (cnt_old + 1) % 256;
    if (pattern_load) m_pat = int'(pattern);
    else if (step_old) m_pat = ((pat_old * 2) + (pat_old / 128)) % 256;
    if ((int'(mode) == 3) && (mode_old != 3)) begin
      m_level = 0;
      m_rising = 1'b1;
    end else if ((mode_old == 3) && step_old) begin
      if (m_rising) begin
        m_level = (lvl_old + 16 > 255) ? 255 : lvl_old + 16;
        if (m_level == 255) m_rising = 1'b0;
      end else begin
        m_level = (lvl_old - 16 < 0) ? 0 : lvl_old - 16;
        if (m_level == 0) m_rising = 1'b1;
      end
    end
    m_mode = int'(mode);
    m_step = s2 && !s3;
    s3 = s2; s2 = s1; s1 = tick_in;
  endtask

  // One clock: advance the model and compare every observable against it.
  task automatic cycle();
    @(posedge clk);
    #1;
    model_edge();
    check("led_out", led_out, m_led);
    check("step_out", step_out, m_step);
    check("pat_q", dut.pat_q, m_pat);
    check("level", dut.level_q, m_level);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_led", led_out, 0);
    check("rst_step", step_out, 0);
    check("rst_pat", dut.pat_q, 0);
    check("rst_level", dut.level_q, 0);
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic tick_pulse();
    tick_in = 1'b1;
    repeat (4) cycle();
    tick_in = 1'b0;
    repeat (4) cycle();
  endtask

  // Expected breathe level after k steps, from the ramp shape directly.
  function automatic int ramp(input int k);
    int p = k % 32;
    int v;
    if (p <= 15) return 16 * p;
    if (p == 16) return 255;
    v = 255 - 16 * (p - 16);
    return (v <= 0) ? 0 : v;
  endfunction

  typedef struct {
    logic [1:0] mode;
    logic [7:0] duty;
    logic [7:0] pat;
    int         exp_high;
  } pwm_vec_t;

  pwm_vec_t vecs[7];

  initial begin
    int highs;
    int steps;

    vecs[0] = '{2'b01, 8'd64,  8'h00, 64};
    vecs[1] = '{2'b01, 8'd0,   8'h00, 0};
    vecs[2] = '{2'b01, 8'd255, 8'h00, 255};
    vecs[3] = '{2'b00, 8'd200, 8'h00, 0};
    vecs[4] = '{2'b10, 8'd128, 8'hFF, 128};
    vecs[5] = '{2'b10, 8'd200, 8'h00, 0};
    vecs[6] = '{2'b10, 8'd100, 8'h80, 100};

    reset_n = 1'b0; tick_in = 1'b0; mode = 2'b01; duty = 8'd64;
    pattern = 8'h00; pattern_load = 1'b0;
    model_reset();
    do_reset();

    // PWM duty table: settle past one full period, then count highs over 256 cycles.
    for (int v = 0; v < 7; v++) begin
      mode = vecs[v].mode; duty = vecs[v].duty; pattern = vecs[v].pat;
      pattern_load = 1'b1;
      cycle();
      pattern_load = 1'b0;
      repeat (300) cycle();
      highs = 0;
      repeat (256) begin
        cycle();
        highs += int'(led_out);
      end
      check($sformatf("pwm_vec%0d", v), highs, vecs[v].exp_high);
    end

    // Duty 64 -> 0 mid-period: old duty finishes the period, then constant off.
    mode = 2'b01; duty = 8'd64;
    repeat (600) cycle();
    for (int i = 0; i < 256 && m_cnt != 0; i++) cycle();
    repeat (10) cycle();
    duty = 8'd0;
    highs = 0;
    repeat (256) begin
      cycle();
      highs += int'(led_out);
    end
    check("duty_tail", highs, 54);
    highs = 0;
    repeat (256) begin
      cycle();
      highs += int'(led_out);
    end
    check("duty_zero", highs, 0);

    // Step latency: pulse on the 3rd edge after the rise only; no pulse on fall.
    repeat (3) cycle();
    tick_in = 1'b1;
    cycle(); check("step_n1", step_out, 0);
    cycle(); check("step_n2", step_out, 0);
    cycle(); check("step_n3", step_out, 1);
    cycle(); check("step_n4", step_out, 0);
    repeat (3) cycle();
    tick_in = 1'b0;
    steps = 0;
    repeat (8) begin
      cycle();
      steps += int'(step_out);
    end
    check("fall_no_step", steps, 0);

    // Pattern rotation 81 -> 03 -> 06 -> 0C, LED gated by the pattern MSB.
    mode = 2'b10; duty = 8'd255; pattern = 8'h81; pattern_load = 1'b1;
    cycle();
    pattern_load = 1'b0;
    check("pat_load", dut.pat_q, 8'h81);
    repeat (300) cycle();
    highs = 0;
    repeat (256) begin
      cycle();
      highs += int'(led_out);
    end
    check("pat_msb1_highs", highs, 255);
    tick_pulse(); check("pat_rot1", dut.pat_q, 8'h03);
    highs = 0;
    repeat (256) begin
      cycle();
      highs += int'(led_out);
    end
    check("pat_msb0_highs", highs, 0);
    tick_pulse(); check("pat_rot2", dut.pat_q, 8'h06);
    tick_pulse(); check("pat_rot3", dut.pat_q, 8'h0C);

    // Load on the same cycle as a step: loaded value, unrotated.
    tick_in = 1'b1;
    repeat (3) cycle();
    check("collide_step", step_out, 1);
    pattern = 8'h5A; pattern_load = 1'b1;
    cycle();
    pattern_load = 1'b0;
    check("collide_pat", dut.pat_q, 8'h5A);
    tick_in = 1'b0;
    repeat (4) cycle();

    // Breathe ramp over 40 steps.
    mode = 2'b11;
    cycle();
    check("breathe_entry", dut.level_q, 0);
    cycle();
    for (int k = 1; k <= 40; k++) begin
      tick_pulse();
      check($sformatf("breathe_k%0d", k), dut.level_q, ramp(k));
    end

    // Reset mid-ramp with tick_in held high: ramp restarts UP from 0.
    repeat (5) tick_pulse();
    tick_in = 1'b1;
    do_reset();
    repeat (6) cycle();
    check("ramp_restart", dut.level_q, 16);
    tick_in = 1'b0;
    repeat (4) cycle();

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(5) == 0) tick_in = ~tick_in;
      if ($urandom_range(199) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(49) == 0) duty = 8'($urandom);
      pattern_load = ($urandom_range(19) == 0);
      pattern = 8'($urandom);
      cycle();
    end
    pattern_load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
